// File: rtl/lsu_axi_write_master_pkg.sv
// lsu_axi_write_master_pkg: AXI response codes and write-master state encoding shared with the peripheral responders
package lsu_axi_write_master_pkg;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_BOTH = 3'd1,
    WAIT_W    = 3'd2,
    WAIT_AW   = 3'd3,
    WAIT_B    = 3'd4
  } state_t;
endpackage

// File: rtl/lsu_axi_write_master.sv
// lsu_axi_write_master: AXI4-Lite single-outstanding write initiator for the LSU store path
// Define LSU_WMASTER_TIMEOUT_EN to add a WAIT_B watchdog that completes with an error after TIMEOUT_CYCLES
module lsu_axi_write_master
  import lsu_axi_write_master_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int STRB_W         = DATA_W / 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [STRB_W-1:0] req_strb,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);
  state_t state, state_nx;
  logic b_err, timeout, b_done;
  assign b_err  = bresp == SLVERR || bresp == DECERR;
  assign b_done = state == WAIT_B && (bvalid || timeout);
`ifdef LSU_WMASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign timeout = state == WAIT_B && !bvalid && cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= state == WAIT_B ? cnt + 1'b1 : '0;
`else
  assign timeout = 1'b0 && TIMEOUT_CYCLES > 0;
`endif
  // Valids decode the state flop only, so an async reset drops them at once
  assign req_ready = state == IDLE;
  assign awvalid   = state == SEND_BOTH || state == WAIT_AW;
  assign wvalid    = state == SEND_BOTH || state == WAIT_W;
  assign bready    = state == WAIT_B;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = req_valid ? SEND_BOTH : IDLE;
      SEND_BOTH: state_nx = awready && wready ? WAIT_B : awready ? WAIT_W : wready ? WAIT_AW : SEND_BOTH;
      WAIT_W:    state_nx = wready ? WAIT_B : WAIT_W;
      WAIT_AW:   state_nx = awready ? WAIT_B : WAIT_AW;
      WAIT_B:    state_nx = b_done ? IDLE : WAIT_B;
      default:   state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      awaddr     <= '0;
      wdata      <= '0;
      wstrb      <= '0;
    end else begin
      state      <= state_nx;
      resp_valid <= b_done;
      resp_err   <= b_done && (bvalid ? b_err : timeout);
      if (state == IDLE && req_valid) begin
        awaddr <= req_addr;
        wdata  <= req_data;
        wstrb  <= req_strb;
      end
    end
  end
endmodule

// File: tb/tb_lsu_axi_write_master.sv
// tb_lsu_axi_write_master: directed bench with a cycle-timeline model of each write transaction
module tb_lsu_axi_write_master;
  import lsu_axi_write_master_pkg::*;
`ifdef LSU_WMASTER_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif
  logic clk = 0, rst = 0;
  logic req_valid, req_ready, resp_valid, resp_err;
  logic [31:0] req_addr, req_data, awaddr, wdata;
  logic [3:0] req_strb, wstrb;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0] bresp;

  lsu_axi_write_master #(.ADDR_W(32), .DATA_W(32), .STRB_W(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_strb(req_strb),
    .resp_valid(resp_valid), .resp_err(resp_err),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  // Transaction timeline: accept cycle, AW/W handshake cycles, B handshake cycle
  int t0 = -100, aw_c = -100, w_c = -100, tb = -100, pr_c = -100;
  bit m_err = 0, pr_err = 0, chk_en = 0;
  logic [31:0] m_addr = 0, m_data = 0, pr_addr = 0, pr_data = 0;
  logic [3:0] m_strb = 0, pr_strb = 0;
  int resp_cnt = 0, last_rc = -1;
  bit last_re = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  function automatic int mx(input int a, input int b);
    return a > b ? a : b;
  endfunction

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      check("req_ready", req_ready, !(cyc > t0 && cyc <= tb));
      check("awvalid", awvalid, cyc > t0 && cyc <= aw_c);
      check("wvalid", wvalid, cyc > t0 && cyc <= w_c);
      check("bready", bready, cyc > mx(aw_c, w_c) && cyc <= tb);
      check("resp_valid", resp_valid, cyc == tb + 1 || cyc == pr_c);
      if (cyc == tb + 1) check("resp_err", resp_err, m_err);
      else if (cyc == pr_c) check("resp_err", resp_err, pr_err);
      check("awaddr", awaddr, cyc > t0 ? m_addr : pr_addr);
      check("wdata", wdata, cyc > t0 ? m_data : pr_data);
      check("wstrb", wstrb, cyc > t0 ? m_strb : pr_strb);
      if (resp_valid) begin
        resp_cnt++;
        last_rc = cyc;
        last_re = resp_err;
      end
    end
  end

  task automatic idle(input int n, input bit bv);
    repeat (n) begin
      @(negedge clk);
      req_valid = 0; awready = 0; wready = 0; bvalid = bv; bresp = SLVERR;
    end
  endtask

  // req_valid stays high with scrambled payload after acceptance to show it is ignored
  task automatic run_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int awd, input int wd, input int bd, input logic [1:0] br,
                         input bit nob, input bit abort, input bit nowait);
    if (!nowait) @(negedge clk);
    pr_c = tb + 1; pr_err = m_err; pr_addr = m_addr; pr_data = m_data; pr_strb = m_strb;
    t0 = cyc; aw_c = t0 + 1 + awd; w_c = t0 + 1 + wd; tb = mx(aw_c, w_c) + 1 + bd;
    m_err = nob ? 1'b1 : br[1]; m_addr = a; m_data = d; m_strb = s;
    forever begin
      req_valid = 1;
      req_addr = cyc == t0 ? a : ~a;
      req_data = cyc == t0 ? d : ~d;
      req_strb = cyc == t0 ? s : ~s;
      awready = cyc == aw_c; wready = cyc == w_c;
      bvalid = !nob && cyc == tb; bresp = br;
      if (cyc == tb || (abort && cyc == mx(aw_c, w_c) + 1)) break;
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  int t_s, n_s;
  initial begin
    req_valid = 0; req_addr = 0; req_data = 0; req_strb = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = OKAY;
    #1 rst = 1;
    #1;
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_bready", bready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_awaddr", awaddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_wstrb", wstrb, 0);
    @(negedge clk);
    rst = 0; chk_en = 1;
    idle(2, 0);
    run_txn(32'hA00003F8, 32'h41, 4'b0001, 0, 0, 0, OKAY, 0, 0, 0);
    t_s = t0;
    idle(3, 1);
    check("zw_resp_cycle", last_rc, t_s + 3);
    check("zw_resp_err", last_re, 0);
    check("zw_resp_count", resp_cnt, 1);
    run_txn(32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 0, 3, 0, OKAY, 0, 0, 0);
    t_s = t0;
    idle(2, 0);
    check("waitw_resp_cycle", last_rc, t_s + 6);
    check("waitw_resp_count", resp_cnt, 2);
    run_txn(32'h2000_0020, 32'hCAFE_F00D, 4'b0110, 3, 0, 1, OKAY, 0, 0, 0);
    t_s = t0;
    idle(2, 0);
    check("waitaw_resp_cycle", last_rc, t_s + 7);
    check("waitaw_resp_count", resp_cnt, 3);
    run_txn(32'h3000_0000, 32'h1234_5678, 4'b1100, 1, 2, 0, SLVERR, 0, 0, 0);
    @(negedge clk);
    #3;
    check("slverr_resp_valid", resp_valid, 1);
    check("slverr_resp_err", resp_err, 1);
    check("slverr_req_ready", req_ready, 1);
    run_txn(32'h4000_0004, 32'h0000_00FF, 4'b0001, 0, 0, 2, DECERR, 0, 0, 1);
    idle(2, 0);
    check("decerr_resp_err", last_re, 1);
    check("b2b_resp_count", resp_cnt, 5);
    n_s = resp_cnt;
    run_txn(32'h5000_0000, 32'h5555_AAAA, 4'hF, 1, 0, 50, OKAY, 0, 1, 0);
    #1;
    check("pre_rst_bready", bready, 1);
    chk_en = 0;
    rst = 1;
    #1;
    check("async_rst_awvalid", awvalid, 0);
    check("async_rst_wvalid", wvalid, 0);
    check("async_rst_bready", bready, 0);
    check("async_rst_resp_valid", resp_valid, 0);
    t0 = -100; aw_c = -100; w_c = -100; tb = -100; pr_c = -100;
    m_addr = 0; m_data = 0; m_strb = 0; pr_addr = 0; pr_data = 0; pr_strb = 0;
    req_valid = 0; awready = 0; wready = 0; bvalid = 0;
    repeat (2) @(negedge clk);
    rst = 0; chk_en = 1;
    idle(3, 0);
    #3;
    check("post_rst_req_ready", req_ready, 1);
    check("post_rst_no_resp", resp_cnt, n_s);
    run_txn(32'h6000_0008, 32'h0BAD_F00D, 4'b0011, 0, 0, 0, OKAY, 0, 0, 0);
    t_s = t0;
    idle(2, 0);
    check("recover_resp_cycle", last_rc, t_s + 3);
`ifdef LSU_WMASTER_TIMEOUT_EN
    run_txn(32'h7000_0000, 32'h7777_7777, 4'hF, 0, 0, TO - 1, OKAY, 1, 0, 0);
    t_s = t0;
    idle(2, 0);
    check("timeout_resp_cycle", last_rc, t_s + 2 + TO);
    check("timeout_resp_err", last_re, 1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
